seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIV, default 50000, clock cycles per digit slot (legal range 2..2^20).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 g  input  4  BCD units digit.
REQ-005 s  input  4  BCD tens digit.
REQ-006 b  input  4  BCD hundreds digit.
REQ-007 q  input  4  BCD thousands digit.
REQ-008 upd  input  1  capture strobe; samples g/s/b/q into the pending buffer on any cycle it is high.
REQ-009 blank_lz  input  1  leading-zero blanking enable.
REQ-010 seg  output  8  active-low segments: seg[0]=a ... seg[6]=g, seg[7]=dp.
REQ-011 an  output  4  active-low digit enables; an[0]=units ... an[3]=thousands.

Function
REQ-012 Divider counter SHALL count 0..DIV-1 and wrap to 0; "tick" SHALL be the cycle in which the counter equals DIV-1.
REQ-013 Digit index idx SHALL advance by 1 on each tick, wrapping from 3 to 0.
REQ-014 On upd=1, g/s/b/q SHALL be written to the pending register and the pend flag SHALL be set.
REQ-015 On a tick with idx=3 (frame boundary) and pend=1, the pending contents SHALL be copied to the display register and pend SHALL be cleared.
REQ-016 When upd=1 coincides with a frame-boundary transfer, the transfer SHALL use the pending contents from before that edge, the new sample SHALL overwrite pending, and pend SHALL remain 1.
REQ-017 The display register SHALL change only at frame boundaries, so no frame mixes old and new digits.
REQ-018 seg and an SHALL be registered and updated only on tick edges, from the next idx and next display contents; both SHALL hold between ticks.
REQ-019 an SHALL equal the bitwise inverse of one-hot(idx_next).
REQ-020 Decode SHALL map 0..9 to the standard active-low patterns (0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 hex); 10..15 SHALL map to "-" (BF); dp SHALL always be 1.
REQ-021 With blank_lz=1, digit k in 1..3 SHALL output seg=FF when it and every higher digit are zero; digit 0 SHALL never be blanked.
REQ-022 With blank_lz=0, all digits SHALL be shown.
REQ-023 blank_lz SHALL be sampled at each tick; it is not buffered.

Reset
REQ-024 During rst=1: divider=0, idx=0, pending=0, display=0, pend=0, an=4'hF, seg=8'hFF.
REQ-025 rst SHALL override upd and tick in the same cycle; mid-frame reset discards pending data.
REQ-026 The first tick after reset release SHALL occur DIV cycles after the release edge and SHALL select idx=1.

Structure
REQ-027 Package seg_pkg SHALL hold the segment-code constants (digits 0..9, DASH, BLANK) and the DIV default.
REQ-028 Decoding SHALL be a combinational sub-module seg_decode (4-bit in, 8-bit active-low out), instantiated once.
REQ-029 Bit widths of the counters SHALL be derived from DIV via $clog2.

Verification (DIV=4)
REQ-030 Reset for 3 cycles, then release -> an=F and seg=FF until the 4th cycle after release; then an=D and seg=C0.
REQ-031 upd with q,b,s,g=1,2,3,4 while idx=1 -> seg unchanged (C0) until the idx 3->0 tick; from then units=99, tens=B0, hundreds=A4, thousands=F9.
REQ-032 blank_lz=1 and value 0042 -> thousands and hundreds seg=FF, tens=99, units=A4; value 0000 -> units=C0, others FF.
REQ-033 g=4'hA loaded -> units slot seg=BF; other slots decode normally.
REQ-034 upd with 5678 pulsed on the frame-boundary edge while 1234 is pending -> the next frame shows 1234; the following frame shows 5678.
REQ-035 rst asserted mid-frame with pend=1 -> outputs return to F/FF; after release the display shows 0000, not the pending value.

Source files
------------

// File: rtl/seg_pkg.sv
//------------------------------------------------------------------------------
// Module : seg_pkg
// Brief  : Segment codes and divider default shared by the seg_scan block.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

    localparam int c_div_default = 50000;

    // Active-low patterns, bit 0 = a ... bit 6 = g, bit 7 = dp (always off)
    localparam logic [7:0] c_seg_0     = 8'hC0;
    localparam logic [7:0] c_seg_1     = 8'hF9;
    localparam logic [7:0] c_seg_2     = 8'hA4;
    localparam logic [7:0] c_seg_3     = 8'hB0;
    localparam logic [7:0] c_seg_4     = 8'h99;
    localparam logic [7:0] c_seg_5     = 8'h92;
    localparam logic [7:0] c_seg_6     = 8'h82;
    localparam logic [7:0] c_seg_7     = 8'hF8;
    localparam logic [7:0] c_seg_8     = 8'h80;
    localparam logic [7:0] c_seg_9     = 8'h90;
    localparam logic [7:0] c_seg_dash  = 8'hBF;
    localparam logic [7:0] c_seg_blank = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/seg_decode.sv
//------------------------------------------------------------------------------
// Module : seg_decode
// Brief  : Combinational BCD to active-low 7-segment decoder.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] dig,
    output logic [7:0] seg
);

    always_comb begin
        seg = c_seg_dash;
        case (dig)
            4'd0:    seg = c_seg_0;
            4'd1:    seg = c_seg_1;
            4'd2:    seg = c_seg_2;
            4'd3:    seg = c_seg_3;
            4'd4:    seg = c_seg_4;
            4'd5:    seg = c_seg_5;
            4'd6:    seg = c_seg_6;
            4'd7:    seg = c_seg_7;
            4'd8:    seg = c_seg_8;
            4'd9:    seg = c_seg_9;
            default: seg = c_seg_dash;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan.sv
//------------------------------------------------------------------------------
// Module : seg_scan
// Brief  : Four-digit multiplexed 7-segment scanner with frame-synchronous
//          digit update and optional leading-zero blanking.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan
    import seg_pkg::*;
#(
    parameter int DIV = c_div_default
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] g,
    input  logic [3:0] s,
    input  logic [3:0] b,
    input  logic [3:0] q,
    input  logic       upd,
    input  logic       blank_lz,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int c_cw = (DIV > 1) ? $clog2(DIV) : 1;

    logic [c_cw-1:0] r_div;
    logic [1:0]      r_idx;
    logic [15:0]     r_pend_dig;
    logic            r_pend;
    logic [15:0]     r_disp;

    logic            w_tick;
    logic            w_frame;
    logic [1:0]      w_idx_nxt;
    logic [15:0]     w_disp_nxt;
    logic [3:0]      w_dig;
    logic [15:0]     w_upper;
    logic            w_blank;
    logic [7:0]      w_dec;

    assign w_tick     = (r_div == c_cw'(DIV - 1));
    assign w_frame    = w_tick && (r_idx == 2'd3) && r_pend;
    assign w_idx_nxt  = r_idx + 2'd1;
    // Output stage looks ahead so the new frame's first slot already shows new data
    assign w_disp_nxt = w_frame ? r_pend_dig : r_disp;
    assign w_dig      = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
    assign w_upper    = w_disp_nxt >> {w_idx_nxt, 2'b00};
    assign w_blank    = blank_lz && (w_idx_nxt != 2'd0) && (w_upper == 16'd0);

    seg_decode u_decode (
        .dig (w_dig),
        .seg (w_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            r_idx      <= 2'd0;
            r_pend_dig <= 16'd0;
            r_pend     <= 1'b0;
            r_disp     <= 16'd0;
            an         <= 4'hF;
            seg        <= c_seg_blank;
        end else begin
            r_div <= w_tick ? '0 : r_div + c_cw'(1);

            // A fresh capture wins over the clear from a same-edge transfer
            if (upd) begin
                r_pend_dig <= {q, b, s, g};
                r_pend     <= 1'b1;
            end else if (w_frame) begin
                r_pend     <= 1'b0;
            end

            if (w_frame) begin
                r_disp <= r_pend_dig;
            end

            if (w_tick) begin
                r_idx <= w_idx_nxt;
                an    <= ~(4'b0001 << w_idx_nxt);
                seg   <= w_blank ? c_seg_blank : w_dec;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan.sv
//------------------------------------------------------------------------------
// Module : tb_seg_scan
// Brief  : Self-checking bench for seg_scan against a behavioural display model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] g = 4'd0, s = 4'd0, b = 4'd0, q = 4'd0;
    logic       upd = 1'b0;
    logic       blank_lz = 1'b0;
    logic [7:0] seg;
    logic [3:0] an;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .g        (g),
        .s        (s),
        .b        (b),
        .q        (q),
        .upd      (upd),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Model state: digits held as plain integer arrays, index 0 = units
    int         m_cnt = 0;
    int         m_idx = 0;
    int         m_pend = 0;
    int         m_pd[4] = '{0, 0, 0, 0};
    int         m_dp[4] = '{0, 0, 0, 0};
    logic [7:0] m_seg = 8'hFF;
    logic [3:0] m_an = 4'hF;
    logic [7:0] code_tab[16];

    initial begin
        code_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                     8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] slot_code(input int k, input int d[4], input logic bl);
        bit all_zero = 1'b1;
        for (int j = k; j < 4; j++) if (d[j] != 0) all_zero = 1'b0;
        if (bl && k > 0 && all_zero) return 8'hFF;
        return code_tab[d[k]];
    endfunction

    task automatic model_edge();
        int in_d[4];
        in_d = '{int'(g), int'(s), int'(b), int'(q)};
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_pend = 0;
            m_pd = '{0, 0, 0, 0}; m_dp = '{0, 0, 0, 0};
            m_an = 4'hF; m_seg = 8'hFF;
        end else begin
            if (m_cnt == DIV - 1) begin
                if (m_idx == 3 && m_pend != 0) begin
                    m_dp = m_pd;
                    m_pend = 0;
                end
                m_idx = (m_idx + 1) % 4;
                m_an = 4'hF;
                m_an[m_idx] = 1'b0;
                m_seg = slot_code(m_idx, m_dp, blank_lz);
            end
            m_cnt = (m_cnt + 1) % DIV;
            if (upd) begin
                m_pd = in_d;
                m_pend = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("seg", seg, m_seg);
        chk("an", {4'h0, an}, {4'h0, m_an});
    endtask

    task automatic load(input int vq, input int vb, input int vs, input int vg);
        q = 4'(vq); b = 4'(vb); s = 4'(vs); g = 4'(vg);
        upd = 1'b1;
        step();
        upd = 1'b0;
    endtask

    task automatic wait_slot(input int k, input logic [7:0] exp_seg);
        logic [3:0] want;
        want = ~(4'b0001 << k);
        for (int i = 0; i < 10 * DIV && an != want; i++) step();
        chk("slot_reach", {4'h0, an}, {4'h0, want});
        chk("slot_seg", seg, exp_seg);
    endtask

    initial begin
        // Reset and first tick
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_seg", seg, 8'hFF);
            chk("rst_an", {4'h0, an}, 8'h0F);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pre_tick_seg", seg, 8'hFF);
            chk("pre_tick_an", {4'h0, an}, 8'h0F);
        end
        step();
        chk("first_tick_an", {4'h0, an}, 8'h0D);
        chk("first_tick_seg", seg, 8'hC0);

        // Capture mid-frame, shown only from the next frame
        load(1, 2, 3, 4);
        wait_slot(2, 8'hC0);
        wait_slot(0, 8'h99);
        wait_slot(1, 8'hB0);
        wait_slot(2, 8'hA4);
        wait_slot(3, 8'hF9);

        // Leading-zero blanking
        blank_lz = 1'b1;
        load(0, 0, 4, 2);
        wait_slot(0, 8'hA4);
        wait_slot(1, 8'h99);
        wait_slot(2, 8'hFF);
        wait_slot(3, 8'hFF);
        load(0, 0, 0, 0);
        wait_slot(0, 8'hC0);
        wait_slot(1, 8'hFF);
        wait_slot(2, 8'hFF);
        wait_slot(3, 8'hFF);

        // Non-BCD digit shows a dash
        blank_lz = 1'b0;
        load(0, 0, 0, 10);
        wait_slot(0, 8'hBF);
        wait_slot(1, 8'hC0);

        // Capture colliding with the frame-boundary transfer
        load(1, 2, 3, 4);
        for (int i = 0; i < 10 * DIV && !(m_cnt == DIV - 1 && m_idx == 3); i++) step();
        load(5, 6, 7, 8);
        chk("collide_an", {4'h0, an}, 8'h0E);
        chk("collide_seg", seg, 8'h99);
        wait_slot(3, 8'hF9);
        wait_slot(0, 8'h80);
        wait_slot(3, 8'h92);

        // Mid-frame reset discards pending data
        load(9, 9, 9, 9);
        step();
        rst = 1'b1;
        step();
        chk("midrst_seg", seg, 8'hFF);
        chk("midrst_an", {4'h0, an}, 8'h0F);
        step();
        rst = 1'b0;
        wait_slot(3, 8'hC0);
        wait_slot(0, 8'hC0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            upd = ($urandom_range(0, 5) == 0);
            g = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 9));
            s = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
            b = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            q = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
